// File: rtl/mem_port_ctrl_pkg.sv
// Shared definitions for the Phaethon RAM-side memory port controller:
// FSM state encoding, sticky error bit positions and the default fill word.
package mem_port_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        IDLE    = 2'd1,
        RD_WAIT = 2'd2,
        ACK     = 2'd3
    } ctrlState_t;

    localparam int ERR_MISALIGN = 0;
    localparam int ERR_RANGE    = 1;
    localparam int ERR_BUSY     = 2;
    localparam int ERR_BOTH     = 3;

    localparam logic [31:0] DEFAULT_BAD_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/mem_port_ctrl_if.sv
// CPU-side request/acknowledge bus between the core (master) and the
// RAM-side controller (slave).
interface mem_port_ctrl_if;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read_req;
    logic        cpu_write_req;
    logic [31:0] cpu_rdata;
    logic        cpu_read_ack;
    logic        cpu_write_ack;

    modport master (
        output cpu_addr, cpu_wdata, cpu_read_req, cpu_write_req,
        input  cpu_rdata, cpu_read_ack, cpu_write_ack
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_read_req, cpu_write_req,
        output cpu_rdata, cpu_read_ack, cpu_write_ack
    );
endinterface

// File: rtl/mem_rd_pipe.sv
// Read-ack timing pipe: a READ_LATENCY-deep shift register carrying a
// read-valid flag and its out-of-range tag alongside the SRAM read data.
module mem_rd_pipe #(
    parameter int READ_LATENCY = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic inValid,
    input  logic inOor,
    output logic outValid,
    output logic outOor
);
    logic [READ_LATENCY-1:0] validReg;
    logic [READ_LATENCY-1:0] oorReg;
    logic [READ_LATENCY-1:0] validNext;
    logic [READ_LATENCY-1:0] oorNext;

    genvar gi;
    generate
        for (gi = 0; gi < READ_LATENCY; gi++) begin : gStage
            if (gi == 0) begin : gHead
                assign validNext[gi] = inValid;
                assign oorNext[gi]   = inOor;
            end else begin : gBody
                assign validNext[gi] = validReg[gi-1];
                assign oorNext[gi]   = oorReg[gi-1];
            end
        end
    endgenerate

    // Advance every stage by one each edge; reset empties the pipe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validReg <= '0;
            oorReg   <= '0;
        end else begin
            validReg <= validNext;
            oorReg   <= oorNext;
        end
    end

    assign outValid = validReg[READ_LATENCY-1];
    assign outOor   = oorReg[READ_LATENCY-1];
endmodule

// File: rtl/mem_port_ctrl.sv
// RAM-side partner of the core memory port: boot loader fill, then
// single-outstanding read/write service against a synchronous word SRAM.
module mem_port_ctrl
    import mem_port_ctrl_pkg::*;
#(
    parameter int          AW           = 12,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BAD_DATA     = DEFAULT_BAD_DATA
) (
    input  logic          clk,
    input  logic          reset,
    mem_port_ctrl_if.slave cpu,
    input  logic          ld_valid,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    output logic          ld_ready,
    output logic          boot_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic [3:0]    err_status
);
    ctrlState_t    stateReg, stateNext;
    logic [AW-1:0] ptrReg, ptrNext;
    logic          bootDoneReg, bootDoneNext;
    logic          memEnReg, memEnNext;
    logic          memWeReg, memWeNext;
    logic [AW-1:0] memAddrReg, memAddrNext;
    logic [31:0]   memWdataReg, memWdataNext;
    logic [31:0]   rdataReg, rdataNext;
    logic          readAckReg, readAckNext;
    logic          writeAckReg, writeAckNext;
    logic [3:0]    errReg, errNext;
    logic          readIssueReg, readIssueNext;
    logic          readOorReg, readOorNext;

    logic          anyReq;
    logic          misaligned;
    logic          inRange;
    logic [AW-1:0] wordIdx;
    logic          pipeValid;
    logic          pipeOor;

    assign anyReq     = cpu.cpu_read_req | cpu.cpu_write_req;
    assign misaligned = |cpu.cpu_addr[1:0];
    assign inRange    = (cpu.cpu_addr[31:AW+2] == '0);
    assign wordIdx    = cpu.cpu_addr[AW+1:2];

    // The pipe is loaded on the edge where the SRAM samples the read, so its
    // output lines up with the edge at which mem_rdata is valid.
    mem_rd_pipe #(.READ_LATENCY(READ_LATENCY)) rdPipe (
        .clk      (clk),
        .reset    (reset),
        .inValid  (readIssueReg),
        .inOor    (readOorReg),
        .outValid (pipeValid),
        .outOor   (pipeOor)
    );

    // State and registered outputs; reset drops any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg     <= BOOT;
            ptrReg       <= '0;
            bootDoneReg  <= 1'b0;
            memEnReg     <= 1'b0;
            memWeReg     <= 1'b0;
            memAddrReg   <= '0;
            memWdataReg  <= '0;
            rdataReg     <= '0;
            readAckReg   <= 1'b0;
            writeAckReg  <= 1'b0;
            errReg       <= '0;
            readIssueReg <= 1'b0;
            readOorReg   <= 1'b0;
        end else begin
            stateReg     <= stateNext;
            ptrReg       <= ptrNext;
            bootDoneReg  <= bootDoneNext;
            memEnReg     <= memEnNext;
            memWeReg     <= memWeNext;
            memAddrReg   <= memAddrNext;
            memWdataReg  <= memWdataNext;
            rdataReg     <= rdataNext;
            readAckReg   <= readAckNext;
            writeAckReg  <= writeAckNext;
            errReg       <= errNext;
            readIssueReg <= readIssueNext;
            readOorReg   <= readOorNext;
        end
    end

    // Next-state selection.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            BOOT:    if (ld_valid && (ld_last || ptrReg == '1)) stateNext = IDLE;
            IDLE:    if (cpu.cpu_write_req) stateNext = ACK;
                     else if (cpu.cpu_read_req) stateNext = RD_WAIT;
            RD_WAIT: if (pipeValid) stateNext = ACK;
            ACK:     if (readAckReg || writeAckReg) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Datapath and output values for the next edge.
    always_comb begin
        ptrNext       = ptrReg;
        bootDoneNext  = bootDoneReg;
        memEnNext     = 1'b0;
        memWeNext     = 1'b0;
        memAddrNext   = memAddrReg;
        memWdataNext  = memWdataReg;
        rdataNext     = rdataReg;
        readAckNext   = 1'b0;
        writeAckNext  = 1'b0;
        errNext       = errReg;
        readIssueNext = 1'b0;
        readOorNext   = readOorReg;
        case (stateReg)
            BOOT: begin
                if (anyReq) errNext[ERR_BUSY] = 1'b1;
                if (ld_valid) begin
                    memEnNext    = 1'b1;
                    memWeNext    = 1'b1;
                    memAddrNext  = ptrReg;
                    memWdataNext = ld_data;
                    ptrNext      = ptrReg + AW'(1);
                    if (ld_last || ptrReg == '1) bootDoneNext = 1'b1;
                end
            end
            IDLE: begin
                if (anyReq) begin
                    if (misaligned) errNext[ERR_MISALIGN] = 1'b1;
                    if (!inRange)   errNext[ERR_RANGE]    = 1'b1;
                    memAddrNext = wordIdx;
                end
                if (cpu.cpu_write_req) begin
                    // Out-of-range writes are acknowledged but never reach the SRAM.
                    if (cpu.cpu_read_req) errNext[ERR_BOTH] = 1'b1;
                    memEnNext    = inRange;
                    memWeNext    = inRange;
                    memWdataNext = cpu.cpu_wdata;
                end else if (cpu.cpu_read_req) begin
                    memEnNext     = 1'b1;
                    readIssueNext = 1'b1;
                    readOorNext   = !inRange;
                end
            end
            RD_WAIT: begin
                if (anyReq) errNext[ERR_BUSY] = 1'b1;
                if (pipeValid) begin
                    rdataNext   = pipeOor ? BAD_DATA : mem_rdata;
                    readAckNext = 1'b1;
                end
            end
            ACK: begin
                if (anyReq) errNext[ERR_BUSY] = 1'b1;
                // Entered from a write with no ack yet: raise it for one cycle.
                if (!(readAckReg || writeAckReg)) writeAckNext = 1'b1;
            end
            default: ;
        endcase
    end

    assign ld_ready          = (stateReg == BOOT) && !reset;
    assign boot_done         = bootDoneReg;
    assign mem_en            = memEnReg;
    assign mem_we            = memWeReg;
    assign mem_addr          = memAddrReg;
    assign mem_wdata         = memWdataReg;
    assign err_status        = errReg;
    assign cpu.cpu_rdata     = rdataReg;
    assign cpu.cpu_read_ack  = readAckReg;
    assign cpu.cpu_write_ack = writeAckReg;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// Self-checking bench for mem_port_ctrl: directed vector table, randomized
// accesses against a word-array reference, and hand-written boot/busy/reset
// sequences.
module tb_mem_port_ctrl;
    localparam int          AW    = 12;
    localparam int          RL    = 1;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BAD   = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          reset;
    logic          ld_valid, ld_last, ld_ready, boot_done;
    logic [31:0]   ld_data;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    err_status;

    mem_port_ctrl_if cpuBus();

    mem_port_ctrl #(.AW(AW), .READ_LATENCY(RL), .BAD_DATA(BAD)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpuBus.slave),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .boot_done  (boot_done),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .err_status (err_status)
    );

    always #5 clk = ~clk;

    // SRAM model: word array, read data appears RL edges after the sampling edge.
    logic [31:0] sram [DEPTH];
    logic [31:0] rdPipe [RL];
    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) sram[k] <= '0;
        end else if (mem_en && mem_we) begin
            sram[mem_addr] <= mem_wdata;
        end
        if (mem_en && !mem_we) rdPipe[0] <= sram[mem_addr];
        for (int k = 1; k < RL; k++) rdPipe[k] <= rdPipe[k-1];
    end
    assign mem_rdata = rdPipe[RL-1];

    // Reference state
    logic [31:0] refMem [DEPTH];
    logic [3:0]  refErr;
    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clearRef();
        for (int k = 0; k < DEPTH; k++) refMem[k] = '0;
        refErr = '0;
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_rdata"}, cpuBus.cpu_rdata, 0);
        check({tag, "_acks"}, {cpuBus.cpu_read_ack, cpuBus.cpu_write_ack}, 0);
        check({tag, "_ldReady"}, ld_ready, 0);
        check({tag, "_bootDone"}, boot_done, 0);
        check({tag, "_memEnWe"}, {mem_en, mem_we}, 0);
        check({tag, "_memAddr"}, mem_addr, 0);
        check({tag, "_memWdata"}, mem_wdata, 0);
        check({tag, "_err"}, err_status, 0);
    endtask

    // Reference: byte address -> word, sticky errors, memory update, latency.
    task automatic modelAccess(input bit isWrite, input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] expData, output int expLat);
        bit inR;
        int idx;
        inR = (addr >> (AW + 2)) == 0;
        idx = int'((addr >> 2) % DEPTH);
        if (addr % 4 != 0) refErr[0] = 1'b1;
        if (!inR) refErr[1] = 1'b1;
        expData = '0;
        if (isWrite) begin
            if (inR) refMem[idx] = wdata;
            expLat = 1;
        end else begin
            expData = inR ? refMem[idx] : BAD;
            expLat = RL + 1;
        end
    endtask

    // One request pulse, wait (bounded) for its ack, then verify the ack falls.
    task automatic doAccess(input bit isWrite, input bit alsoRead, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata, output int lat,
                            output logic [AW-1:0] memAddrSeen, output logic memEnSeen);
        logic ack;
        @(negedge clk);
        cpuBus.cpu_addr = addr;
        cpuBus.cpu_wdata = wdata;
        cpuBus.cpu_write_req = isWrite;
        cpuBus.cpu_read_req = !isWrite || alsoRead;
        @(posedge clk); #1;
        memAddrSeen = mem_addr;
        memEnSeen = mem_en;
        cpuBus.cpu_write_req = 1'b0;
        cpuBus.cpu_read_req = 1'b0;
        lat = -1;
        rdata = '0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            ack = isWrite ? cpuBus.cpu_write_ack : cpuBus.cpu_read_ack;
            if (ack) begin
                lat = i;
                rdata = cpuBus.cpu_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        check("ackFall", {cpuBus.cpu_read_ack, cpuBus.cpu_write_ack}, 0);
    endtask

    typedef struct {
        bit          isWrite;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expData;
        int          expLat;
        logic [3:0]  expErr;
        logic [AW-1:0] expMemAddr;
    } vec_t;

    task automatic runRandom(input int n, input int window);
        logic [31:0] addr, wdata, expData, rdata;
        int expLat, lat, sel;
        bit isWrite, inR;
        logic [AW-1:0] ma;
        logic me;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = $urandom_range(0, 9);
            isWrite = $urandom_range(0, 1) == 1;
            wdata = $urandom;
            if (sel == 0) addr = $urandom | 32'h0001_0000;
            else if (sel == 1) addr = ($urandom_range(0, window - 1) << 2) | $urandom_range(1, 3);
            else addr = $urandom_range(0, window - 1) << 2;
            inR = (addr >> (AW + 2)) == 0;
            modelAccess(isWrite, addr, wdata, expData, expLat);
            doAccess(isWrite, 1'b0, addr, wdata, rdata, lat, ma, me);
            check($sformatf("rnd%0d_lat", i), lat, expLat);
            if (!isWrite) check($sformatf("rnd%0d_data", i), rdata, expData);
            check($sformatf("rnd%0d_err", i), err_status, refErr);
            if (inR) begin
                check($sformatf("rnd%0d_memAddr", i), ma, (addr >> 2) % DEPTH);
                check($sformatf("rnd%0d_memEn", i), me, 1);
            end else if (isWrite) begin
                check($sformatf("rnd%0d_memEnOor", i), me, 0);
            end
        end
    endtask

    initial begin
        vec_t vecs [6];
        logic [31:0] bootWords [3];
        logic [31:0] rdata, expData;
        int lat, expLat;
        logic [AW-1:0] ma;
        logic me;

        bootWords[0] = 32'hA000_0001;
        bootWords[1] = 32'hA100_0002;
        bootWords[2] = 32'hA200_0003;
        vecs[0] = '{0, 32'h0000_0008, 32'h0,         32'hA200_0003, 2, 4'b0000, 12'd2};
        vecs[1] = '{1, 32'h0000_0010, 32'h0000_1234, 32'h0,         1, 4'b0000, 12'd4};
        vecs[2] = '{0, 32'h0000_0010, 32'h0,         32'h0000_1234, 2, 4'b0000, 12'd4};
        vecs[3] = '{0, 32'h0000_0006, 32'h0,         32'hA100_0002, 2, 4'b0001, 12'd1};
        vecs[4] = '{0, 32'h0010_0000, 32'h0,         32'hDEADBEEF,  2, 4'b0011, 12'd0};
        vecs[5] = '{0, 32'h0000_0000, 32'h0,         32'hA000_0001, 2, 4'b0011, 12'd0};

        reset = 1'b1;
        cpuBus.cpu_addr = '0;
        cpuBus.cpu_wdata = '0;
        cpuBus.cpu_read_req = 1'b0;
        cpuBus.cpu_write_req = 1'b0;
        ld_valid = 1'b0;
        ld_last = 1'b0;
        ld_data = '0;
        clearRef();
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;
        #1 check("bootLdReady", ld_ready, 1);

        // Boot load of three words, ld_last on the third
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data = bootWords[k];
            ld_last = (k == 2);
            @(posedge clk); #1;
            check($sformatf("boot%0d_memEnWe", k), {mem_en, mem_we}, 2'b11);
            check($sformatf("boot%0d_memAddr", k), mem_addr, k);
            check($sformatf("boot%0d_memWdata", k), mem_wdata, bootWords[k]);
            check($sformatf("boot%0d_bootDone", k), boot_done, (k == 2));
            refMem[k] = bootWords[k];
        end
        @(negedge clk);
        ld_valid = 1'b0;
        ld_last = 1'b0;
        @(posedge clk); #1;
        check("postBoot_ldReady", ld_ready, 0);
        check("postBoot_memEn", mem_en, 0);
        check("postBoot_bootDone", boot_done, 1);

        // Directed vector table
        for (int v = 0; v < 6; v++) begin
            modelAccess(vecs[v].isWrite, vecs[v].addr, vecs[v].wdata, expData, expLat);
            doAccess(vecs[v].isWrite, 1'b0, vecs[v].addr, vecs[v].wdata, rdata, lat, ma, me);
            $display("vec%0d %s addr=%h lat=%0d rdata=%h err=%b", v, vecs[v].isWrite ? "WR" : "RD",
                     vecs[v].addr, lat, rdata, err_status);
            check($sformatf("vec%0d_lat", v), lat, vecs[v].expLat);
            if (!vecs[v].isWrite) check($sformatf("vec%0d_data", v), rdata, vecs[v].expData);
            check($sformatf("vec%0d_err", v), err_status, vecs[v].expErr);
            check($sformatf("vec%0d_memAddr", v), ma, vecs[v].expMemAddr);
        end

        runRandom(120, 64);

        // Simultaneous read and write: write wins, err[3]
        modelAccess(1'b1, 32'h20, 32'hCAFE_0006, expData, expLat);
        refErr[3] = 1'b1;
        doAccess(1'b1, 1'b1, 32'h20, 32'hCAFE_0006, rdata, lat, ma, me);
        $display("both addr=00000020 lat=%0d err=%b", lat, err_status);
        check("both_lat", lat, 1);
        check("both_err", err_status, refErr);

        // Request during RD_WAIT is dropped and flags err[2]
        @(negedge clk);
        cpuBus.cpu_addr = 32'h20;
        cpuBus.cpu_read_req = 1'b1;
        @(posedge clk); #1;
        cpuBus.cpu_read_req = 1'b0;
        @(negedge clk);
        cpuBus.cpu_addr = 32'h24;
        cpuBus.cpu_wdata = 32'h5555_5555;
        cpuBus.cpu_write_req = 1'b1;
        @(posedge clk); #1;
        cpuBus.cpu_write_req = 1'b0;
        check("busy_noEarlyAck", cpuBus.cpu_read_ack, 0);
        @(posedge clk); #1;
        refErr[2] = 1'b1;
        $display("busy read addr=00000020 ack=%b rdata=%h err=%b", cpuBus.cpu_read_ack, cpuBus.cpu_rdata, err_status);
        check("busy_ack", cpuBus.cpu_read_ack, 1);
        check("busy_data", cpuBus.cpu_rdata, 32'hCAFE_0006);
        check("busy_err", err_status, refErr);
        @(posedge clk); #1;
        check("busy_ackFall", cpuBus.cpu_read_ack, 0);
        modelAccess(1'b0, 32'h24, 32'h0, expData, expLat);
        doAccess(1'b0, 1'b0, 32'h24, 32'h0, rdata, lat, ma, me);
        $display("dropped write check addr=00000024 rdata=%h", rdata);
        check("dropped_data", rdata, expData);

        // Reset while in RD_WAIT: no ack, everything cleared
        @(negedge clk);
        cpuBus.cpu_addr = 32'h20;
        cpuBus.cpu_read_req = 1'b1;
        @(posedge clk); #1;
        cpuBus.cpu_read_req = 1'b0;
        #1 reset = 1'b1;
        #1 checkAllZero("rstRdWait");
        clearRef();
        repeat (3) begin
            @(posedge clk); #1;
            check("rstHold_noAck", cpuBus.cpu_read_ack, 0);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check("rstRel_noAck", cpuBus.cpu_read_ack, 0);
            check("rstRel_bootDone", boot_done, 0);
            check("rstRel_err", err_status, 0);
        end
        $display("reset in RD_WAIT: ack=%b boot_done=%b err=%b", cpuBus.cpu_read_ack, boot_done, err_status);

        // Boot without ld_last until the pointer wraps; a CPU request in BOOT flags err[2]
        @(negedge clk);
        ld_valid = 1'b1;
        ld_last = 1'b0;
        ld_data = 32'h5A5A_0000;
        cpuBus.cpu_addr = '0;
        cpuBus.cpu_read_req = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            @(posedge clk); #1;
            cpuBus.cpu_read_req = 1'b0;
            refMem[i] = 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0001);
            if (i == 0) check("wrap_bootReqErr", err_status, 4'b0100);
            if (i == DEPTH - 2) check("wrap_notDone", boot_done, 0);
            if (i == DEPTH - 1) check("wrap_done", boot_done, 1);
            if (i < DEPTH - 1) ld_data = 32'h5A5A_0000 ^ (32'(i + 1) * 32'h0001_0001);
        end
        ld_valid = 1'b0;
        refErr = 4'b0100;
        $display("wrap boot: boot_done=%b err=%b", boot_done, err_status);
        @(posedge clk); #1;
        check("wrap_ldReady", ld_ready, 0);

        runRandom(40, DEPTH);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule
